// File: rtl/sha_dispatch_ctrl.sv
// -----------------------------------------------------------------------------
// sha_dispatch_ctrl
//
// Nonce-dispatch and result-collection controller for an array of NCORE SHA
// cores. The cores share a round-cycle counter. Each core gets its own nonce,
// interleaved across the inclusive window [nonce_start, nonce_end]. At each
// round end the per-core hit bits are sampled into a pending vector. The
// pending hits are then pushed one per cycle into a small result FIFO that is
// read through a ready/valid port.
//
// Optional feature (compile-time macro SHA_STOP_ON_HIT_EN):
//   defined   - a round that samples any valid hit ends the search after
//               that round. Pending hits are still drained before done.
//   undefined - the whole window is always scanned.
//
// Parameters:
//   NCORE      number of cores driven (1..16)
//   ROUNDS     cycles per hash round (>= NCORE+1, so the drain of one
//              round's hits finishes before the next round end)
//   FIFO_DEPTH result FIFO entries (power of 2, >= 2)
//
// Ports:
//   clk, n_rst          clock (rising edge), asynchronous active-low reset
//   start               begin a search (sampled only in IDLE)
//   abort               stop the search at the next edge, no done pulse
//   nonce_start/end     inclusive window bounds, latched on accepted start
//   cycle               round cycle index broadcast to the cores
//   core_nonce          nonce for core i in bits [32i+31:32i]
//   core_result         per core, 33 bits: bit 32 = hit, bits 31:0 = nonce
//   busy                controller not IDLE
//   done                one-cycle pulse when a search completes
//   exhausted           sticky: the window was fully searched
//   overflow            sticky: a hit was dropped because the FIFO was full
//   res_valid/res_ready result FIFO handshake (pop on valid & ready)
//   res_nonce/res_core  FIFO head entry (zero when empty)
// -----------------------------------------------------------------------------
module sha_dispatch_ctrl #(
  parameter  int NCORE      = 4,
  parameter  int ROUNDS     = 64,
  parameter  int FIFO_DEPTH = 4,
  localparam int CW         = $clog2(ROUNDS),
  localparam int IW         = (NCORE > 1) ? $clog2(NCORE) : 1
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                start,
  input  logic                abort,
  input  logic [31:0]         nonce_start,
  input  logic [31:0]         nonce_end,
  output logic [CW-1:0]       cycle,
  output logic [32*NCORE-1:0] core_nonce,
  input  logic [33*NCORE-1:0] core_result,
  output logic                busy,
  output logic                done,
  output logic                exhausted,
  output logic                overflow,
  output logic                res_valid,
  output logic [31:0]         res_nonce,
  output logic [IW-1:0]       res_core,
  input  logic                res_ready
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEARCH,
    ST_FLUSH
  } state_t;

  typedef struct packed {
    logic [31:0]   nonce;
    logic [IW-1:0] core;
  } entry_t;

  // Controller state
  state_t            state_q, state_d;
  logic [CW-1:0]     cycle_q, cycle_d;
  logic [31:0]       base_q, base_d;
  logic [31:0]       end_q, end_d;
  logic [NCORE-1:0]  pending_q, pending_d;
  logic              exhausted_q, exhausted_d;
  logic              overflow_q, overflow_d;
  logic              done_q, done_d;

  // Result FIFO
  entry_t            mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       count;

  // Datapath helpers
  logic [NCORE-1:0]  lane_valid;
  logic [NCORE-1:0]  sample;
  logic [NCORE-1:0]  clr_mask;
  logic              round_end;
  logic              last_round;
  logic              stop_hit;
  logic              push;
  logic              pop;
  logic              full;
  logic              wr_en;
  logic              drop;
  entry_t            push_entry;

  // Lane validity and round-end sample. The 33-bit compare keeps a window
  // ending at 0xFFFFFFFF from wrapping back into range.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // through the block can leave it unassigned and infer a latch.
    lane_valid = '0;
    sample     = '0;
    for (int i = 0; i < NCORE; i++) begin
      lane_valid[i] = ({1'b0, base_q} + 33'(i)) <= {1'b0, end_q};
      sample[i]     = core_result[33*i+32] & lane_valid[i];
    end
  end

  assign round_end  = (state_q == ST_SEARCH) && (cycle_q == CW'(ROUNDS-1));
  assign last_round = ({1'b0, base_q} + 33'(NCORE)) > {1'b0, end_q};

`ifdef SHA_STOP_ON_HIT_EN
  assign stop_hit = |sample;
`else
  assign stop_hit = 1'b0;
`endif

  // Drain: the lowest-index pending bit is pushed each busy cycle. An abort
  // discards whatever is still pending instead of pushing it.
  always_comb begin
    push       = 1'b0;
    clr_mask   = '0;
    push_entry = '0;
    if (state_q != ST_IDLE && !abort) begin
      for (int i = 0; i < NCORE; i++) begin
        if (pending_q[i] && !push) begin
          push             = 1'b1;
          clr_mask[i]      = 1'b1;
          push_entry.nonce = core_result[33*i +: 32];
          push_entry.core  = IW'(i);
        end
      end
    end
  end

  assign pop   = res_valid & res_ready;
  assign full  = (count == (AW+1)'(FIFO_DEPTH));
  // A pop in the same cycle frees the head slot, so a full FIFO still
  // accepts the push.
  assign wr_en = push & (~full | pop);
  assign drop  = push & full & ~pop;

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    cycle_d     = cycle_q;
    base_d      = base_q;
    end_d       = end_q;
    pending_d   = pending_q & ~clr_mask;
    exhausted_d = exhausted_q;
    overflow_d  = overflow_q | drop;
    done_d      = 1'b0;

    if (abort && state_q != ST_IDLE) begin
      // Abort wins over round-end processing: no sample, no exhaustion.
      state_d   = ST_IDLE;
      cycle_d   = '0;
      pending_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          cycle_d = '0;
          if (start) begin
            end_d       = nonce_end;
            exhausted_d = 1'b0;
            overflow_d  = 1'b0;
            if (nonce_end < nonce_start) begin
              exhausted_d = 1'b1;
              state_d     = ST_FLUSH;
            end else begin
              base_d  = nonce_start;
              state_d = ST_SEARCH;
            end
          end
        end

        ST_SEARCH: begin
          if (round_end) begin
            cycle_d   = '0;
            pending_d = pending_d | sample;
            if (last_round) begin
              exhausted_d = 1'b1;
              state_d     = ST_FLUSH;
            end else if (stop_hit) begin
              state_d = ST_FLUSH;
            end else begin
              base_d = base_q + 32'(NCORE);
            end
          end else begin
            cycle_d = cycle_q + CW'(1);
          end
        end

        ST_FLUSH: begin
          if (pending_q == '0) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end

        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and FIFO pointer registers
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= ST_IDLE;
      cycle_q     <= '0;
      base_q      <= '0;
      end_q       <= '0;
      pending_q   <= '0;
      exhausted_q <= 1'b0;
      overflow_q  <= 1'b0;
      done_q      <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
    end else begin
      // NOTE: non-blocking assignments here, so every register samples its
      // pre-edge value and the update order inside the block does not matter.
      state_q     <= state_d;
      cycle_q     <= cycle_d;
      base_q      <= base_d;
      end_q       <= end_d;
      pending_q   <= pending_d;
      exhausted_q <= exhausted_d;
      overflow_q  <= overflow_d;
      done_q      <= done_d;
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: the FIFO storage has no reset. Only the pointers and the count
  // need one, and the head output is forced to zero while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= push_entry;
  end

  // Outputs
  always_comb begin
    core_nonce = '0;
    for (int i = 0; i < NCORE; i++) begin
      if (state_q == ST_SEARCH) core_nonce[32*i +: 32] = base_q + 32'(i);
    end
  end

  assign cycle     = cycle_q;
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign exhausted = exhausted_q;
  assign overflow  = overflow_q;
  assign res_valid = (count != '0);
  assign res_nonce = res_valid ? mem[rd_ptr].nonce : 32'h0;
  assign res_core  = res_valid ? mem[rd_ptr].core  : '0;

endmodule
